irq_detect_block: RTL
=====================

IRQ_DETECT_BLOCK -- requirements
Module: irq_detect_block

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, the number of external IRQ channels (2..16).
REQ-002 SHALL have parameter VW, default $clog2(N_IRQ), the vector width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  block clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 irq_pin  input  N_IRQ  raw external IRQ pins, asynchronous to clk.
REQ-007 iscr  input  2*N_IRQ  sense mode, 2 bits per channel i at [2i+1:2i]: 00 low level, 01 falling edge, 10 rising edge, 11 both edges.
REQ-008 ier  input  N_IRQ  per-channel request enable.
REQ-009 irq_clr  input  N_IRQ  per-channel flag-clear pulse from the clear logic.
REQ-010 irq_ack  input  1  CPU accepts the pending request (exception handling start).
REQ-011 exc_done  input  1  one-cycle pulse at end of exception handling.
REQ-012 isr  output  N_IRQ  interrupt status flags.
REQ-013 irq_req  output  1  interrupt request to CPU.
REQ-014 irq_vec  output  VW  channel index of the current request.
REQ-015 busy  output  1  high while in SERVICE state.

Function
REQ-016 Each irq_pin bit SHALL pass through a 2-flop synchronizer (s1, s2), followed by a history flop s3 <= s2.
REQ-017 Detect per channel: low level = !s2; falling = s3 & !s2; rising = !s3 & s2; both = s3 ^ s2.
REQ-018 isr[i] SHALL be set on the edge after detect[i] is true, regardless of ier[i].
REQ-019 isr[i] SHALL be cleared on the edge after irq_clr[i]=1 with no detect[i]; with both true the same cycle, set wins (isr[i]=1).
REQ-020 Latency: a pin transition captured by s1 at edge k SHALL make isr visible after edge k+2; irq_req SHALL rise after edge k+3 when in IDLE.
REQ-021 pend = isr & ier; priority SHALL be fixed, lowest index highest.
REQ-022 FSM states IDLE, REQ, SERVICE; encoding is free.
REQ-023 IDLE: if pend != 0, go to REQ, load irq_vec with the highest-priority pending index, assert irq_req.
REQ-024 REQ: irq_req=1 and irq_vec frozen; a newly pending higher-priority channel SHALL NOT change irq_vec.
REQ-025 REQ with irq_ack=1 SHALL go to SERVICE, deassert irq_req, and hold irq_vec.
REQ-026 REQ with pend[irq_vec]=0 and irq_ack=0 (withdrawn) SHALL go to IDLE and deassert irq_req the next cycle.
REQ-027 REQ with irq_ack=1 and the flag withdrawn in the same cycle SHALL give ack priority (go to SERVICE).
REQ-028 SERVICE: busy=1, irq_req=0; exc_done=1 SHALL return to IDLE; irq_ack is ignored.
REQ-029 IDLE re-arbitrates on the cycle after returning, so back-to-back requests have exactly one idle cycle between irq_req pulses.
REQ-030 irq_ack in IDLE SHALL be ignored; exc_done outside SERVICE SHALL be ignored.
REQ-031 Changing iscr mode SHALL take effect on the next detection cycle; no spurious edge SHALL be generated by a mode change alone.

Reset
REQ-032 rst=1 SHALL immediately force s1, s2, s3 to 1 (pins idle high), isr=0, irq_req=0, irq_vec=0, busy=0, FSM=IDLE, including mid-handshake.
REQ-033 After rst deasserts, a pin held low in falling mode SHALL produce exactly one isr set; in level mode it SHALL set isr every cycle while low.

Verification
REQ-034 ch3 falling mode, ier=0x08: drive irq_pin[3] 1->0 -> isr=0x08 after 3 edges, irq_req=1, irq_vec=3 the next cycle; ack -> busy=1; exc_done -> IDLE.
REQ-035 ch1 and ch5 pending together, ier=0xFF -> irq_vec=1 first; after ack and exc_done, irq_clr[1] pulsed -> irq_vec=5 on the next request.
REQ-036 In REQ with vec=4, pulse irq_clr[4] with no ack -> irq_req drops the next cycle, state IDLE.
REQ-037 irq_clr[2] and a rising edge detected on ch2 in the same cycle -> isr[2] remains 1.
REQ-038 Assert rst during SERVICE -> busy, irq_req, isr all 0 immediately without a clock edge; after release, no request until a new detection.
REQ-039 Both-edge mode on ch0: pulse 0->1->0 of width 4 cycles, with irq_clr after the first set -> two isr set events observed.

Source files
------------

// File: rtl/irq_detect_block.sv
// External interrupt front end: pin synchronisation, per-channel sense-mode
// detection, status flags, and a fixed-priority request/acknowledge FSM.
module irq_detect_block #(
    parameter int N_IRQ = 8,
    parameter int VW    = $clog2(N_IRQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IRQ-1:0]     irq_pin,
    input  logic [2*N_IRQ-1:0]   iscr,
    input  logic [N_IRQ-1:0]     ier,
    input  logic [N_IRQ-1:0]     irq_clr,
    input  logic                 irq_ack,
    input  logic                 exc_done,
    output logic [N_IRQ-1:0]     isr,
    output logic                 irq_req,
    output logic [VW-1:0]        irq_vec,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             r_state;
    logic [N_IRQ-1:0]   r_s1_p0;
    logic [N_IRQ-1:0]   r_s2_p1;
    logic [N_IRQ-1:0]   r_s3_p2;
    logic [N_IRQ-1:0]   r_isr;
    logic               r_irq_req;
    logic [VW-1:0]      r_irq_vec;
    logic               r_busy;
    logic [N_IRQ-1:0]   w_detect;
    logic [N_IRQ-1:0]   w_pend;

    function automatic logic [VW-1:0] prio_idx(input logic [N_IRQ-1:0] v);
        prio_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) prio_idx = VW'(i);
        end
    endfunction

    // Synchroniser and history stages; idle-high pins so reset produces no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_p0 <= '1;
            r_s2_p1 <= '1;
            r_s3_p2 <= '1;
        end else begin
            r_s1_p0 <= irq_pin;
            r_s2_p1 <= r_s1_p0;
            r_s3_p2 <= r_s2_p1;
        end
    end

    // Detection stage: both inputs are real history, so a mode switch cannot fake an edge
    always_comb begin
        w_detect = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            case (iscr[2*i +: 2])
                2'b00:   w_detect[i] = ~r_s2_p1[i];
                2'b01:   w_detect[i] = r_s3_p2[i] & ~r_s2_p1[i];
                2'b10:   w_detect[i] = ~r_s3_p2[i] & r_s2_p1[i];
                default: w_detect[i] = r_s3_p2[i] ^ r_s2_p1[i];
            endcase
        end
    end

    // Flag stage: a new detection beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_isr <= '0;
        end else begin
            r_isr <= (r_isr & ~irq_clr) | w_detect;
        end
    end

    assign w_pend = r_isr & ier;

    // Request stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_irq_req <= 1'b0;
            r_irq_vec <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pend != '0) begin
                        r_state   <= REQ;
                        r_irq_req <= 1'b1;
                        r_irq_vec <= prio_idx(w_pend);
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        r_state   <= SERVICE;
                        r_irq_req <= 1'b0;
                        r_busy    <= 1'b1;
                    end else if (!w_pend[r_irq_vec]) begin
                        r_state   <= IDLE;
                        r_irq_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (exc_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_irq_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign isr     = r_isr;
    assign irq_req = r_irq_req;
    assign irq_vec = r_irq_vec;
    assign busy    = r_busy;

endmodule
